// File: rtl/avalon_multi_timer.sv
// Multi-channel Avalon-MM down-counting timer with per-channel prescaler,
// sticky timeout flags, snapshot capture and a global interrupt-pending word.
module avalon_multi_timer #(
   parameter int NUM_CH       = 4,
   parameter int CNT_W        = 32,
   parameter int RESET_PERIOD = 49999
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              chipselect,
   input  logic              write_n,
   input  logic              read_n,
   input  logic [5:0]        address,
   input  logic [31:0]       writedata,
   output logic [31:0]       readdata,
   output logic              irq,
   output logic [NUM_CH-1:0] timeout_pulse
);

   localparam logic [CNT_W-1:0] RST_VAL = CNT_W'(RESET_PERIOD);

   logic [CNT_W-1:0] counter   [NUM_CH];
   logic [CNT_W-1:0] period    [NUM_CH];
   logic [CNT_W-1:0] snap      [NUM_CH];
   logic [7:0]       presc     [NUM_CH];
   logic [7:0]       presc_cnt [NUM_CH];
   logic [NUM_CH-1:0] run, to, ito, cont;

   logic              wr, wr_glob;
   logic [NUM_CH-1:0] wr_stat, wr_ctrl, wr_per, wr_snap;
   logic [NUM_CH-1:0] tick, timeout, to_clr;
   logic [31:0]       rd_mux;

   assign wr      = chipselect & ~write_n;
   assign wr_glob = wr && (address == 6'd32);
   assign irq     = |(to & ito);

   // A PERIOD write in the same cycle as a zero-count tick suppresses the timeout.
   always_comb begin
      wr_stat = '0;
      wr_ctrl = '0;
      wr_per  = '0;
      wr_snap = '0;
      tick    = '0;
      timeout = '0;
      to_clr  = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         if (wr && !address[5] && (address[4:2] == 3'(c))) begin
            wr_stat[c] = (address[1:0] == 2'd0);
            wr_ctrl[c] = (address[1:0] == 2'd1);
            wr_per[c]  = (address[1:0] == 2'd2);
            wr_snap[c] = (address[1:0] == 2'd3);
         end
         tick[c]    = run[c] && (presc_cnt[c] == presc[c]);
         timeout[c] = tick[c] && (counter[c] == '0) && !wr_per[c];
         to_clr[c]  = wr_stat[c] || (wr_glob && writedata[c]);
      end
   end

   always_comb begin
      rd_mux = '0;
      if (address == 6'd32)
         rd_mux = 32'(to);
      for (int c = 0; c < NUM_CH; c++) begin
         if (!address[5] && (address[4:2] == 3'(c))) begin
            case (address[1:0])
               2'd0:    rd_mux = {30'd0, run[c], to[c]};
               2'd1:    rd_mux = {16'd0, presc[c], 6'd0, cont[c], ito[c]};
               2'd2:    rd_mux = 32'(period[c]);
               default: rd_mux = 32'(snap[c]);
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int c = 0; c < NUM_CH; c++) begin
            counter[c]   <= RST_VAL;
            period[c]    <= RST_VAL;
            snap[c]      <= '0;
            presc[c]     <= '0;
            presc_cnt[c] <= '0;
         end
         run           <= '0;
         to            <= '0;
         ito           <= '0;
         cont          <= '0;
         timeout_pulse <= '0;
         readdata      <= '0;
      end else begin
         readdata      <= (chipselect && !read_n) ? rd_mux : '0;
         timeout_pulse <= timeout;
         for (int c = 0; c < NUM_CH; c++) begin
            if (wr_per[c]) begin
               period[c]    <= writedata[CNT_W-1:0];
               counter[c]   <= writedata[CNT_W-1:0];
               presc_cnt[c] <= '0;
            end else if (tick[c]) begin
               presc_cnt[c] <= '0;
               if (counter[c] == '0)
                  counter[c] <= period[c];
               else
                  counter[c] <= counter[c] - CNT_W'(1);
            end else if (run[c]) begin
               presc_cnt[c] <= presc_cnt[c] + 8'd1;
            end

            if (wr_snap[c])
               snap[c] <= counter[c];

            if (wr_ctrl[c]) begin
               ito[c]   <= writedata[0];
               cont[c]  <= writedata[1];
               presc[c] <= writedata[15:8];
            end

            // STOP beats START; START only acts on an idle channel.
            if (wr_per[c] || (wr_ctrl[c] && writedata[3]) || (timeout[c] && !cont[c]))
               run[c] <= 1'b0;
            else if (wr_ctrl[c] && writedata[2])
               run[c] <= 1'b1;

            if (timeout[c])
               to[c] <= 1'b1;
            else if (to_clr[c])
               to[c] <= 1'b0;
         end
      end
   end

endmodule

// File: doc/avalon_multi_timer.md
AVALON_MULTI_TIMER -- requirements
Module: avalon_multi_timer

Interface
REQ-001 SHALL accept parameter NUM_CH, default 4, number of independent timer channels (1..8).
REQ-002 SHALL accept parameter CNT_W, default 32, counter/period width in bits (8..32).
REQ-003 SHALL accept parameter RESET_PERIOD, default 49999, period and counter value loaded at reset (truncated to CNT_W).
REQ-004 SHALL have port clk  input  1  system clock; all state on rising edge.
REQ-005 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports chipselect  input  1, write_n  input  1, read_n  input  1, Avalon-MM slave strobes.
REQ-007 SHALL have port address  input  6  word address; channel c owns words 4c..4c+3; word 32 is global IRQ pending.
REQ-008 SHALL have port writedata  input  32  write data.
REQ-009 SHALL have port readdata  output  32  registered read data.
REQ-010 SHALL have port irq  output  1  OR of all channel interrupt requests.
REQ-011 SHALL have port timeout_pulse  output  NUM_CH  one-cycle pulse per channel on each timeout.

Function
REQ-012 Write = chipselect & ~write_n; read data SHALL appear on readdata exactly one cycle after address is presented; unmapped words or channels >= NUM_CH SHALL read 0 and ignore writes.
REQ-013 Word 4c+0 STATUS: bit0 TO (sticky timeout), bit1 RUN; any write SHALL clear TO.
REQ-014 Word 4c+1 CONTROL: bit0 ITO (irq enable), bit1 CONT, bit2 START, bit3 STOP (START/STOP self-clearing, read 0), bits15:8 PRESC; read returns ITO, CONT, PRESC.
REQ-015 Word 4c+2 PERIOD: CNT_W bits, upper bits read 0; a write SHALL load counter with new value next cycle, clear prescaler, and stop the channel (RUN=0).
REQ-016 Word 4c+3 SNAP: any write SHALL capture current counter into snapshot; read returns snapshot.
REQ-017 Prescaler: per-channel 8-bit counter, runs only while RUN=1; tick SHALL assert when prescaler == PRESC, prescaler then returns to 0; PRESC=0 gives tick every cycle.
REQ-018 On tick with counter != 0, counter SHALL decrement by 1.
REQ-019 On tick with counter == 0: TO SHALL set, timeout_pulse[c] SHALL pulse for one cycle, counter SHALL reload PERIOD; if CONT=0 RUN SHALL clear.
REQ-020 Timeout interval SHALL be (PERIOD+1)*(PRESC+1) cycles.
REQ-021 START with RUN=0 SHALL set RUN next cycle without altering counter; START with RUN=1 SHALL have no effect.
REQ-022 STOP SHALL clear RUN, freezing counter and prescaler; START and STOP in the same write: STOP wins.
REQ-023 STATUS write coinciding with a timeout: TO SHALL remain set (event not lost).
REQ-024 PERIOD write coinciding with a tick: PERIOD load wins; no timeout generated.
REQ-025 SNAP write coinciding with decrement SHALL capture pre-decrement value.
REQ-026 Channel irq = TO & ITO; irq SHALL be combinational OR over channels.
REQ-027 Word 32 SHALL read {zeros, TO[NUM_CH-1:0]}; writes SHALL clear TO bits written as 1.
REQ-028 Channels SHALL be fully independent; simultaneous timeouts on several channels SHALL all be recorded.

Reset
REQ-029 On reset_n low, asynchronously: counter and PERIOD = RESET_PERIOD, prescaler = 0, snapshot = 0, RUN = 0, TO = 0, ITO = CONT = PRESC = 0, readdata = 0, timeout_pulse = 0, irq = 0.
REQ-030 Reset asserted mid-count SHALL abort operation; after release channel SHALL remain stopped until START.

Verification
REQ-031 Ch0 PERIOD=4, PRESC=0, CONT=1, ITO=1, START -> timeout_pulse[0] every 5 cycles, irq high after first timeout until STATUS write.
REQ-032 Ch1 PERIOD=2, PRESC=3, CONT=0, START -> single timeout after 12 cycles, RUN=0, counter reads back 2 via SNAP.
REQ-033 Ch2 running, STATUS write same cycle as timeout -> TO reads 1 afterwards.
REQ-034 Ch0 running, PERIOD write of 10 -> RUN=0 next cycle, SNAP reads 10, no pulse.
REQ-035 CONTROL write with START=STOP=1 on running ch3 -> RUN=0; word 32 write 0xF with two TO set -> all TO cleared, irq=0.
REQ-036 reset_n pulsed low mid-count -> all outputs 0, PERIOD reads 49999, no timeout until START.
